// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel writer: geometry defaults, widths, colour
// constants, FSM encoding and the buffered command layout.
package pixel_pkg;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam int FB_ADDR_W = 15;
  localparam int COLOUR_W  = 3;
  localparam int COORD_W   = 8;

  localparam logic [COLOUR_W-1:0] BLACK  = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE  = 3'b111;
  localparam logic [COLOUR_W-1:0] RED    = 3'b100;
  localparam logic [COLOUR_W-1:0] YELLOW = 3'b110;
  localparam logic [COLOUR_W-1:0] GREEN  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PIXEL = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  typedef struct packed {
    logic                fill;
    logic [COLOUR_W-1:0] colour;
    logic [COORD_W-1:0]  y;
    logic [COORD_W-1:0]  x;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Row-major framebuffer address; for 160 columns this reduces to (y<<7)+(y<<5)+x.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input int h_res);
    return FB_ADDR_W'(y) * FB_ADDR_W'(h_res) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous command FIFO with registered occupancy count and full/empty flags.
// Read data is the head entry; there is no write-to-read bypass.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pixel_writer.sv
// Buffers pixel/fill commands and turns them into registered framebuffer writes.
// Define PIXEL_WRITER_FILL_EN to build the full-screen FILL state and counter.
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_x,
  input  logic [7:0]           in_y,
  input  logic [2:0]           in_colour,
  input  logic                 in_fill,
  output logic                 fb_we,
  output logic [14:0]          fb_addr,
  output logic [2:0]           fb_data,
  output logic                 busy,
  output logic [7:0]           drop_count
);

  localparam logic [COORD_W:0] H_LIM = 9'(H_RES);
  localparam logic [COORD_W:0] V_LIM = 9'(V_RES);

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [COLOUR_W-1:0]  col_q, col_d;
  logic                 fb_we_q, fb_we_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [COLOUR_W-1:0]  fb_data_q, fb_data_d;
  logic [7:0]           drop_q, drop_d;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0]     fifo_rdata;
  cmd_t                 rd_cmd;
  logic                 in_range;

`ifdef PIXEL_WRITER_FILL_EN
  localparam logic [FB_ADDR_W-1:0] FILL_LAST = FB_ADDR_W'(H_RES * V_RES - 1);
  logic [FB_ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
`else
  logic fill_unused;
  assign fill_unused = rd_cmd.fill;
`endif

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid & in_ready),
    .wdata ({in_fill, in_colour, in_y, in_x}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_cmd     = cmd_t'(fifo_rdata);
  assign in_ready   = rst & ~fifo_full;
  assign busy       = rst & (~fifo_empty | (state_q != ST_IDLE));
  assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty;
  assign in_range   = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign drop_count = drop_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= BLACK;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= BLACK;
      drop_q     <= 8'd0;
`ifdef PIXEL_WRITER_FILL_EN
      fill_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      col_q      <= col_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      drop_q     <= drop_d;
`ifdef PIXEL_WRITER_FILL_EN
      fill_cnt_q <= fill_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
`ifdef PIXEL_WRITER_FILL_EN
          state_d = rd_cmd.fill ? ST_FILL : ST_PIXEL;
`else
          state_d = ST_PIXEL;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PIXEL: state_d = ST_IDLE;
`ifdef PIXEL_WRITER_FILL_EN
      ST_FILL: begin
        if (fill_cnt_q == FILL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Write strobe defaults low; address/data hold their last value between writes.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    col_d     = col_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    drop_d    = drop_q;
`ifdef PIXEL_WRITER_FILL_EN
    fill_cnt_d = fill_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          x_d   = rd_cmd.x;
          y_d   = rd_cmd.y;
          col_d = rd_cmd.colour;
        end else begin
          x_d   = x_q;
        end
`ifdef PIXEL_WRITER_FILL_EN
        fill_cnt_d = '0;
`endif
      end
      ST_PIXEL: begin
        if (in_range) begin
          fb_we_d   = 1'b1;
          fb_addr_d = pix_addr(x_q, y_q, H_RES);
          fb_data_d = col_q;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end else begin
          drop_d = drop_q;
        end
      end
`ifdef PIXEL_WRITER_FILL_EN
      ST_FILL: begin
        fb_we_d    = 1'b1;
        fb_addr_d  = fill_cnt_q;
        fb_data_d  = col_q;
        fill_cnt_d = fill_cnt_q + FB_ADDR_W'(1);
      end
`endif
      default: begin
        fb_we_d = 1'b0;
      end
    endcase
  end

endmodule
